apb_lsu: RTL

- Parametrised APB load/store unit. It takes the memory-access path out of the microcoded core and generalises it for the next core generation.
- Accepts one load or store request at a time on a valid/ready interface and runs it as APB transfers.
- Steers byte lanes for DATA_WIDTH 32 or 64, sign- or zero-extends loads, splits bus-unaligned accesses into two beats, and reports APB errors, timeouts and alignment faults.
- Sits between the core's execute stage and the system APB interconnect.

---
 rtl/apb_lsu_pkg.sv | 33 +++
 rtl/apb_lsu_lane_align.sv | 65 ++++++
 rtl/apb_lsu.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/apb_lsu_pkg.sv
// apb_lsu_pkg: shared types for the APB load/store unit.
//   lsu_state_t : controller states
//   lsu_size_t  : request size codes (byte, half, word, dword)
//   lsu_err_t   : response error codes
//   size_bits() : number of data bits covered by a size code
package apb_lsu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10,
    RESP   = 2'b11
  } lsu_state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_D = 2'b11
  } lsu_size_t;

  typedef enum logic [1:0] {
    ERR_OK    = 2'b00,
    ERR_PERR  = 2'b01,
    ERR_TMO   = 2'b10,
    ERR_ALIGN = 2'b11
  } lsu_err_t;

  function automatic int unsigned size_bits(input logic [1:0] size);
    return 32'd8 << size;
  endfunction

endpackage

// File: rtl/apb_lsu_lane_align.sv
// lsu_lane_align: combinational byte-lane steering for apb_lsu.
//   Write side (from the incoming request):
//     w_off, w_size, w_data -> mask_lo/mask_hi (beat 1 / beat 2 strobes),
//                              wdata_lo/wdata_hi (beat 1 / beat 2 bus data)
//   Read side (from the registered request and captured bus data):
//     r_off, r_size, r_unsigned, rd_lo (beat 1 word), rd_hi (beat 2 word)
//                           -> rd_ext (right-aligned, sign/zero extended)
module lsu_lane_align
  import apb_lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  localparam int NB = DATA_WIDTH / 8,
  localparam int OW = $clog2(DATA_WIDTH / 8)
) (
  input  logic [OW-1:0]         w_off,
  input  logic [1:0]            w_size,
  input  logic [DATA_WIDTH-1:0] w_data,
  output logic [NB-1:0]         mask_lo,
  output logic [NB-1:0]         mask_hi,
  output logic [DATA_WIDTH-1:0] wdata_lo,
  output logic [DATA_WIDTH-1:0] wdata_hi,
  input  logic [OW-1:0]         r_off,
  input  logic [1:0]            r_size,
  input  logic                  r_unsigned,
  input  logic [DATA_WIDTH-1:0] rd_lo,
  input  logic [DATA_WIDTH-1:0] rd_hi,
  output logic [DATA_WIDTH-1:0] rd_ext
);

  logic [2*NB-1:0]         mask_wide;
  logic [2*DATA_WIDTH-1:0] wdata_wide;
  logic [2*DATA_WIDTH-1:0] rd_cat;
  logic                    sign;
  int unsigned             nbits;

  // Strobes and data are built two bus words wide; the upper word is what
  // spills over into the second beat of a split access.
  always_comb begin
    mask_wide  = ((2*NB)'(1) << (4'd1 << w_size)) - (2*NB)'(1);
    mask_wide  = mask_wide << w_off;
    mask_lo    = mask_wide[NB-1:0];
    mask_hi    = mask_wide[2*NB-1:NB];
    wdata_wide = {{DATA_WIDTH{1'b0}}, w_data} << {w_off, 3'b000};
    wdata_lo   = wdata_wide[DATA_WIDTH-1:0];
    wdata_hi   = wdata_wide[2*DATA_WIDTH-1:DATA_WIDTH];
  end

  // Concatenating beat 2 above beat 1 and shifting down by the offset puts
  // the beat-2 lanes directly above the beat-1 lanes.
  always_comb begin
    rd_cat = {rd_hi, rd_lo} >> {r_off, 3'b000};
    nbits  = size_bits(r_size);
    case (r_size)
      2'b00:   sign = rd_cat[7];
      2'b01:   sign = rd_cat[15];
      2'b10:   sign = rd_cat[31];
      default: sign = rd_cat[63];
    endcase
    rd_ext = '0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      rd_ext[i] = (i < nbits) ? rd_cat[i] : (sign & ~r_unsigned);
    end
  end

endmodule

// File: rtl/apb_lsu.sv
// apb_lsu: APB load/store unit. Runs one load or store at a time as one or
// two APB transfers, with lane steering, load extension and error reporting.
//   clk, rts                 : clock, synchronous active-high reset
//   req_valid/req_ready      : request handshake
//   req_write/size/unsigned  : store flag, size code, zero-extend flag
//   req_addr, req_wdata      : byte address, right-aligned store data
//   rsp_valid/rdata/err      : one-cycle completion with data and error code
//   APB_*                    : APB requester (psel/penable/pwrite/paddr/
//                              pdata/pstb out; prdata/pready/perr in)
module apb_lsu
  import apb_lsu_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int SPLIT_UNALIGNED = 1,
  parameter int TIMEOUT_CYCLES  = 256
) (
  input  logic                    clk,
  input  logic                    rts,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [1:0]              req_size,
  input  logic                    req_unsigned,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_err,
  output logic [ADDR_WIDTH-1:0]   APB_paddr,
  output logic [DATA_WIDTH-1:0]   APB_pdata,
  input  logic [DATA_WIDTH-1:0]   APB_prdata,
  output logic                    APB_psel,
  output logic                    APB_penable,
  output logic                    APB_pwrite,
  output logic [DATA_WIDTH/8-1:0] APB_pstb,
  input  logic                    APB_pready,
  input  logic                    APB_perr
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int OW = $clog2(NB);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  lsu_state_t state, state_n;
  logic                  beat, beat_n;
  logic                  r_write, r_write_n;
  logic [1:0]            r_size, r_size_n;
  logic                  r_unsigned, r_unsigned_n;
  logic [OW-1:0]         r_off, r_off_n;
  logic [NB-1:0]         r_mask_hi, r_mask_hi_n;
  logic [DATA_WIDTH-1:0] r_wdata_hi, r_wdata_hi_n;
  logic [DATA_WIDTH-1:0] r_rd_lo, r_rd_lo_n;
  logic [TW-1:0]         tmo_cnt, tmo_cnt_n;

  logic                  psel_n, penable_n, pwrite_n;
  logic [ADDR_WIDTH-1:0] paddr_n;
  logic [DATA_WIDTH-1:0] pdata_n;
  logic [NB-1:0]         pstb_n;
  logic                  rsp_valid_n;
  logic [DATA_WIDTH-1:0] rsp_rdata_n;
  logic [1:0]            rsp_err_n;

  logic [NB-1:0]         mask_lo, mask_hi;
  logic [DATA_WIDTH-1:0] wdata_lo, wdata_hi, rd_ext;
  logic [DATA_WIDTH-1:0] rd_lo, rd_hi;
  logic                  fault;

  assign req_ready = (state == IDLE) && !rts;

  // On a single-beat read the live bus word is beat 1; on the second beat the
  // stored first word is beat 1 and the live word supplies the upper lanes.
  assign rd_lo = beat ? r_rd_lo : APB_prdata;
  assign rd_hi = beat ? APB_prdata : '0;

  lsu_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .w_off      (req_addr[OW-1:0]),
    .w_size     (req_size),
    .w_data     (req_wdata),
    .mask_lo    (mask_lo),
    .mask_hi    (mask_hi),
    .wdata_lo   (wdata_lo),
    .wdata_hi   (wdata_hi),
    .r_off      (r_off),
    .r_size     (r_size),
    .r_unsigned (r_unsigned),
    .rd_lo      (rd_lo),
    .rd_hi      (rd_hi),
    .rd_ext     (rd_ext)
  );

  assign fault = (req_size > 2'(OW)) || ((SPLIT_UNALIGNED == 0) && (|mask_hi));

  always_ff @(posedge clk) begin
    if (rts) begin
      state       <= IDLE;
      beat        <= 1'b0;
      r_write     <= 1'b0;
      r_size      <= '0;
      r_unsigned  <= 1'b0;
      r_off       <= '0;
      r_mask_hi   <= '0;
      r_wdata_hi  <= '0;
      r_rd_lo     <= '0;
      tmo_cnt     <= '0;
      APB_psel    <= 1'b0;
      APB_penable <= 1'b0;
      APB_pwrite  <= 1'b0;
      APB_paddr   <= '0;
      APB_pdata   <= '0;
      APB_pstb    <= '1;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= ERR_OK;
    end else begin
      state       <= state_n;
      beat        <= beat_n;
      r_write     <= r_write_n;
      r_size      <= r_size_n;
      r_unsigned  <= r_unsigned_n;
      r_off       <= r_off_n;
      r_mask_hi   <= r_mask_hi_n;
      r_wdata_hi  <= r_wdata_hi_n;
      r_rd_lo     <= r_rd_lo_n;
      tmo_cnt     <= tmo_cnt_n;
      APB_psel    <= psel_n;
      APB_penable <= penable_n;
      APB_pwrite  <= pwrite_n;
      APB_paddr   <= paddr_n;
      APB_pdata   <= pdata_n;
      APB_pstb    <= pstb_n;
      rsp_valid   <= rsp_valid_n;
      rsp_rdata   <= rsp_rdata_n;
      rsp_err     <= rsp_err_n;
    end
  end

  // All bus and response outputs are registered; this block computes their
  // values for the state being entered, so rsp_valid is high exactly in RESP.
  always_comb begin
    state_n      = state;
    beat_n       = beat;
    r_write_n    = r_write;
    r_size_n     = r_size;
    r_unsigned_n = r_unsigned;
    r_off_n      = r_off;
    r_mask_hi_n  = r_mask_hi;
    r_wdata_hi_n = r_wdata_hi;
    r_rd_lo_n    = r_rd_lo;
    tmo_cnt_n    = tmo_cnt;
    psel_n       = APB_psel;
    penable_n    = APB_penable;
    pwrite_n     = APB_pwrite;
    paddr_n      = APB_paddr;
    pdata_n      = APB_pdata;
    pstb_n       = APB_pstb;
    rsp_valid_n  = 1'b0;
    rsp_rdata_n  = '0;
    rsp_err_n    = ERR_OK;

    unique case (state)
      IDLE: begin
        if (req_valid) begin
          r_write_n    = req_write;
          r_size_n     = req_size;
          r_unsigned_n = req_unsigned;
          r_off_n      = req_addr[OW-1:0];
          r_mask_hi_n  = mask_hi;
          r_wdata_hi_n = wdata_hi;
          beat_n       = 1'b0;
          if (fault) begin
            state_n     = RESP;
            rsp_valid_n = 1'b1;
            rsp_err_n   = ERR_ALIGN;
          end else begin
            state_n   = SETUP;
            psel_n    = 1'b1;
            penable_n = 1'b0;
            pwrite_n  = req_write;
            paddr_n   = {req_addr[ADDR_WIDTH-1:OW], {OW{1'b0}}};
            pdata_n   = wdata_lo;
            pstb_n    = req_write ? mask_lo : '1;
          end
        end
      end

      SETUP: begin
        state_n   = ACCESS;
        penable_n = 1'b1;
        tmo_cnt_n = '0;
      end

      ACCESS: begin
        if (APB_pready) begin
          if (APB_perr) begin
            state_n     = RESP;
            psel_n      = 1'b0;
            penable_n   = 1'b0;
            rsp_valid_n = 1'b1;
            rsp_err_n   = ERR_PERR;
          end else if (!beat && (|r_mask_hi)) begin
            state_n   = SETUP;
            beat_n    = 1'b1;
            penable_n = 1'b0;
            r_rd_lo_n = APB_prdata;
            paddr_n   = APB_paddr + ADDR_WIDTH'(NB);
            pdata_n   = r_wdata_hi;
            pstb_n    = r_write ? r_mask_hi : '1;
          end else begin
            state_n     = RESP;
            psel_n      = 1'b0;
            penable_n   = 1'b0;
            rsp_valid_n = 1'b1;
            rsp_rdata_n = r_write ? '0 : rd_ext;
          end
        end else if ((TIMEOUT_CYCLES != 0) && (tmo_cnt == TMO_LAST)) begin
          state_n     = RESP;
          psel_n      = 1'b0;
          penable_n   = 1'b0;
          rsp_valid_n = 1'b1;
          rsp_err_n   = ERR_TMO;
        end else begin
          tmo_cnt_n = tmo_cnt + 1'b1;
        end
      end

      RESP: begin
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule
